// File: rtl/snn_timestep_sched.sv
// Run-level scheduler: sequences N sweeps of the neuron core and captures
// timestep-tagged spike events into a first-word-fall-through FIFO.
//
// state       | meaning
// S_IDLE      | waiting for a run request
// S_LAUNCH    | start pulse to the sweep controller
// S_WAIT_CORE | sweep in progress, capturing spikes
// S_TS_END    | publish timestep spike count, advance timestep
// S_FINISH    | run-complete pulse
module snn_timestep_sched #(
    parameter int ADDR_WIDTH = 14,
    parameter int TS_WIDTH   = 8,
    parameter int CNT_WIDTH  = 14,
    parameter int FIFO_AW    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_run_start,
    input  logic [TS_WIDTH-1:0]   i_num_timesteps,
    input  logic                  i_abort,
    output logic                  o_core_start,
    input  logic                  i_core_done,
    input  logic                  i_spike_valid,
    input  logic [ADDR_WIDTH-1:0] i_spike_addr,
    output logic                  o_evt_valid,
    output logic [ADDR_WIDTH-1:0] o_evt_addr,
    output logic [TS_WIDTH-1:0]   o_evt_ts,
    input  logic                  i_evt_ready,
    output logic [TS_WIDTH-1:0]   o_cur_ts,
    output logic [CNT_WIDTH-1:0]  o_ts_spike_count,
    output logic                  o_busy,
    output logic                  o_run_done,
    output logic                  o_overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_CORE,
        S_TS_END,
        S_FINISH
    } state_t;

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int EW    = TS_WIDTH + ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                state_q, state_d;
    logic [TS_WIDTH-1:0]   num_q, num_d;
    logic [TS_WIDTH-1:0]   cur_ts_q, cur_ts_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  ts_cnt_q, ts_cnt_d;
    logic                  ovf_q, ovf_d;
    logic [FIFO_AW:0]      wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]      rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]         mem_q [DEPTH];

    logic                  busy, empty, full, pop, accept, push;
    logic [CNT_WIDTH-1:0]  cnt_inc;

    assign busy    = (state_q != S_IDLE);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign pop     = !empty && i_evt_ready;
    // An abort flushes the FIFO this cycle, so a coincident spike is discarded.
    assign accept  = i_spike_valid && busy && !i_abort;
    assign push    = accept && (!full || pop);
    assign cnt_inc = (accept && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        cur_ts_d = cur_ts_q;
        cnt_d    = cnt_inc;
        ts_cnt_d = ts_cnt_q;
        ovf_d    = ovf_q || (accept && full && !pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        if (i_abort) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_run_start) begin
                        num_d    = i_num_timesteps;
                        cur_ts_d = '0;
                        cnt_d    = '0;
                        ovf_d    = 1'b0;
                        state_d  = (i_num_timesteps == '0) ? S_FINISH : S_LAUNCH;
                    end
                end
                S_LAUNCH:    state_d = S_WAIT_CORE;
                S_WAIT_CORE: if (i_core_done) state_d = S_TS_END;
                S_TS_END: begin
                    ts_cnt_d = cnt_inc;
                    cnt_d    = '0;
                    if (cur_ts_q == num_q - 1'b1) begin
                        state_d = S_FINISH;
                    end else begin
                        cur_ts_d = cur_ts_q + 1'b1;
                        state_d  = S_LAUNCH;
                    end
                end
                S_FINISH:    state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            num_q    <= '0;
            cur_ts_q <= '0;
            cnt_q    <= '0;
            ts_cnt_q <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            cur_ts_q <= cur_ts_d;
            cnt_q    <= cnt_d;
            ts_cnt_q <= ts_cnt_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {cur_ts_q, i_spike_addr};
        end
    end

    assign o_evt_valid              = !empty;
    assign {o_evt_ts, o_evt_addr}   = empty ? '0 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign o_core_start             = (state_q == S_LAUNCH);
    assign o_run_done               = (state_q == S_FINISH);
    assign o_busy                   = busy;
    assign o_cur_ts                 = cur_ts_q;
    assign o_ts_spike_count         = ts_cnt_q;
    assign o_overflow               = ovf_q;

endmodule

// File: tb/tb_snn_timestep_sched.sv
// Bench for snn_timestep_sched: behavioural sweep-core model feeding an
// expected-event queue, checked against FIFO pops, plus per-scenario tasks.
module tb_snn_timestep_sched;

    localparam int AW = 14;
    localparam int TW = 8;
    localparam int CW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_run_start = 1'b0;
    logic [TW-1:0] i_num_timesteps = '0;
    logic          i_abort = 1'b0;
    logic          o_core_start;
    logic          i_core_done = 1'b0;
    logic          i_spike_valid = 1'b0;
    logic [AW-1:0] i_spike_addr = '0;
    logic          o_evt_valid;
    logic [AW-1:0] o_evt_addr;
    logic [TW-1:0] o_evt_ts;
    logic          i_evt_ready = 1'b0;
    logic [TW-1:0] o_cur_ts;
    logic [CW-1:0] o_ts_spike_count;
    logic          o_busy;
    logic          o_run_done;
    logic          o_overflow;

    always #5 clk = ~clk;

    snn_timestep_sched #(
        .ADDR_WIDTH(AW), .TS_WIDTH(TW), .CNT_WIDTH(CW), .FIFO_AW(4)
    ) dut (
        .clk(clk), .rst(rst),
        .i_run_start(i_run_start), .i_num_timesteps(i_num_timesteps),
        .i_abort(i_abort), .o_core_start(o_core_start), .i_core_done(i_core_done),
        .i_spike_valid(i_spike_valid), .i_spike_addr(i_spike_addr),
        .o_evt_valid(o_evt_valid), .o_evt_addr(o_evt_addr), .o_evt_ts(o_evt_ts),
        .i_evt_ready(i_evt_ready), .o_cur_ts(o_cur_ts),
        .o_ts_spike_count(o_ts_spike_count), .o_busy(o_busy),
        .o_run_done(o_run_done), .o_overflow(o_overflow)
    );

    int total = 0;
    int bad   = 0;

    logic [TW+AW-1:0] sb[$];
    logic [TW+AW-1:0] exp_evt;
    int pop_cnt = 0;
    bit mon_en  = 1'b0;

    bit            model_en  = 1'b0;
    int            model_dly = 20;
    int            model_off = 0;
    int            model_n   = 0;
    int            model_ts  = -1;
    logic [AW-1:0] model_addr[32];

    // Pops happen on the next rising edge; compare the head half a cycle earlier.
    always @(negedge clk) begin
        if (mon_en && o_evt_valid && i_evt_ready) begin
            pop_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL evt_unexpected: got ts=%0d addr=%0d, expected no event", o_evt_ts, o_evt_addr);
            end else begin
                exp_evt = sb.pop_front();
                if ({o_evt_ts, o_evt_addr} !== exp_evt) begin
                    bad++;
                    $display("FAIL evt_data: got ts=%0d addr=%0d, expected ts=%0d addr=%0d",
                             o_evt_ts, o_evt_addr, exp_evt[TW+AW-1:AW], exp_evt[AW-1:0]);
                end
            end
        end
    end

    // Sweep-core model: spikes at cycles off+1..off+n after start, done at cycle dly.
    always begin
        @(posedge clk); #1;
        if (model_en && o_core_start) begin
            model_ts++;
            for (int c = 1; c <= model_dly; c++) begin
                @(posedge clk); #1;
                if (c > model_off && c <= model_off + model_n) begin
                    i_spike_valid = 1'b1;
                    i_spike_addr  = model_addr[c-model_off-1];
                    sb.push_back({model_ts[TW-1:0], model_addr[c-model_off-1]});
                end else begin
                    i_spike_valid = 1'b0;
                end
                i_core_done = (c == model_dly);
            end
            @(posedge clk); #1;
            i_spike_valid = 1'b0;
            i_core_done   = 1'b0;
        end
    end

    task automatic run_wait(input int maxc, input int glitch,
                            output int starts, output int dones, output int cycles);
        starts = 0; dones = 0; cycles = 0;
        while (cycles < maxc && dones == 0) begin
            @(posedge clk); #2;
            cycles++;
            i_run_start = (glitch != 0 && cycles == glitch);
            if (glitch != 0 && cycles == glitch) i_num_timesteps = 8'd7;
            if (o_core_start) starts++;
            if (o_run_done) dones++;
        end
        i_run_start = 1'b0;
    endtask

    task automatic pulse_run(input logic [TW-1:0] n);
        @(posedge clk); #2;
        i_run_start = 1'b1;
        i_num_timesteps = n;
    endtask

    task automatic set_model(input int n, input int off, input int dly, input int base, input int step);
        model_n = n; model_off = off; model_dly = dly; model_ts = -1;
        for (int i = 0; i < n; i++) model_addr[i] = AW'(base + i*step);
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({o_core_start, o_evt_valid, o_evt_addr, o_evt_ts, o_cur_ts, o_ts_spike_count,
             o_busy, o_run_done, o_overflow} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b valid=%b cur_ts=%0d cnt=%0d ovf=%b, expected all 0",
                     o_busy, o_evt_valid, o_cur_ts, o_ts_spike_count, o_overflow);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_normal_run();
        int starts, dones, last_done, cyc;
        sb.delete(); pop_cnt = 0; mon_en = 1'b1; i_evt_ready = 1'b1;
        set_model(2, 0, 20, 5, 4);
        model_en = 1'b1;
        pulse_run(8'd3);
        @(posedge clk); #2;
        i_run_start = 1'b0;
        total++;
        if (!(o_busy === 1'b1 && o_core_start === 1'b1)) begin
            bad++;
            $display("FAIL start_latency: got busy=%b core_start=%b, expected 1 1", o_busy, o_core_start);
        end
        starts = 1; dones = 0; last_done = -100; cyc = 0;
        while (cyc < 200 && dones == 0) begin
            @(posedge clk); #2;
            cyc++;
            if (o_core_start) begin
                starts++;
                total++;
                if (cyc != last_done + 2) begin
                    bad++;
                    $display("FAIL restart_latency: got cycle %0d, expected %0d", cyc, last_done + 2);
                end
                total++;
                if (o_ts_spike_count !== 14'd2) begin
                    bad++;
                    $display("FAIL ts_count_mid: got %0d expected 2", o_ts_spike_count);
                end
            end
            if (o_run_done) begin
                dones++;
                total++;
                if (cyc != last_done + 2) begin
                    bad++;
                    $display("FAIL done_latency: got cycle %0d, expected %0d", cyc, last_done + 2);
                end
            end
            if (i_core_done) last_done = cyc;
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL normal_timeout: got %0d run_done pulses, expected 1", dones);
        end
        @(posedge clk); #2;
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_fall: got %b expected 0", o_busy);
        end
        for (int i = 0; i < 6; i++) begin
            if (o_run_done || o_core_start) dones++;
            @(posedge clk); #2;
        end
        total++;
        if (starts != 3 || dones != 1) begin
            bad++;
            $display("FAIL normal_pulses: got starts=%0d dones=%0d, expected 3 1", starts, dones);
        end
        total++;
        if (pop_cnt != 6 || sb.size() != 0) begin
            bad++;
            $display("FAIL normal_events: got pops=%0d left=%0d, expected 6 0", pop_cnt, sb.size());
        end
        total++;
        if (o_cur_ts !== 8'd2 || o_ts_spike_count !== 14'd2 || o_overflow !== 1'b0) begin
            bad++;
            $display("FAIL normal_final: got cur_ts=%0d cnt=%0d ovf=%b, expected 2 2 0",
                     o_cur_ts, o_ts_spike_count, o_overflow);
        end
        model_en = 1'b0;
    endtask

    task automatic test_zero_timesteps();
        int extra;
        pulse_run(8'd0);
        @(posedge clk); #2;
        i_run_start = 1'b0;
        total++;
        if (!(o_run_done === 1'b1 && o_busy === 1'b1 && o_core_start === 1'b0)) begin
            bad++;
            $display("FAIL zero_first: got done=%b busy=%b start=%b, expected 1 1 0",
                     o_run_done, o_busy, o_core_start);
        end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            if (o_busy || o_core_start || o_run_done) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL zero_after: got %0d active cycles, expected 0", extra);
        end
    endtask

    task automatic test_idle_spike();
        @(posedge clk); #2;
        i_spike_valid = 1'b1; i_spike_addr = 14'd77;
        @(posedge clk); #2;
        i_spike_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (o_evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_spike: got evt_valid=%b expected 0", o_evt_valid);
        end
    endtask

    task automatic test_ignored_start();
        int starts, dones, cyc;
        sb.delete(); pop_cnt = 0; i_evt_ready = 1'b1;
        set_model(2, 0, 20, 5, 4);
        model_en = 1'b1;
        pulse_run(8'd2);
        run_wait(200, 5, starts, dones, cyc);
        repeat (4) @(posedge clk);
        #2;
        total++;
        if (starts != 2 || dones != 1 || o_cur_ts !== 8'd1) begin
            bad++;
            $display("FAIL ignored_start: got starts=%0d dones=%0d cur_ts=%0d, expected 2 1 1",
                     starts, dones, o_cur_ts);
        end
        total++;
        if (pop_cnt != 4 || sb.size() != 0) begin
            bad++;
            $display("FAIL ignored_events: got pops=%0d left=%0d, expected 4 0", pop_cnt, sb.size());
        end
        model_en = 1'b0;
    endtask

    task automatic test_overflow();
        int starts, dones, cyc;
        sb.delete(); i_evt_ready = 1'b0;
        set_model(20, 0, 30, 100, 1);
        model_en = 1'b1;
        pulse_run(8'd1);
        run_wait(100, 0, starts, dones, cyc);
        @(posedge clk); #2;
        total++;
        if (dones != 1 || starts != 1) begin
            bad++;
            $display("FAIL ovf_run: got starts=%0d dones=%0d, expected 1 1", starts, dones);
        end
        total++;
        if (o_overflow !== 1'b1 || o_ts_spike_count !== 14'd20 || o_evt_valid !== 1'b1) begin
            bad++;
            $display("FAIL ovf_status: got ovf=%b cnt=%0d valid=%b, expected 1 20 1",
                     o_overflow, o_ts_spike_count, o_evt_valid);
        end
        while (sb.size() > 16) void'(sb.pop_back());
        pop_cnt = 0;
        i_evt_ready = 1'b1;
        for (int i = 0; i < 40 && o_evt_valid; i++) begin
            @(posedge clk); #2;
        end
        i_evt_ready = 1'b0;
        total++;
        if (pop_cnt != 16 || sb.size() != 0) begin
            bad++;
            $display("FAIL ovf_drain: got pops=%0d left=%0d, expected 16 0", pop_cnt, sb.size());
        end
        model_en = 1'b0;
    endtask

    task automatic test_full_push_pop();
        int starts, dones, cyc;
        sb.delete(); i_evt_ready = 1'b0;
        pulse_run(8'd1);
        @(posedge clk); #2;
        i_run_start = 1'b0;
        pop_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            i_spike_valid = 1'b1;
            i_spike_addr  = AW'(200 + i);
            sb.push_back({8'd0, AW'(200 + i)});
            if (i == 16) i_evt_ready = 1'b1;
            @(posedge clk); #2;
        end
        i_spike_valid = 1'b0;
        i_evt_ready   = 1'b0;
        total++;
        if (o_overflow !== 1'b0 || o_evt_valid !== 1'b1) begin
            bad++;
            $display("FAIL full_pushpop_ovf: got ovf=%b valid=%b, expected 0 1", o_overflow, o_evt_valid);
        end
        i_core_done = 1'b1;
        @(posedge clk); #2;
        i_core_done = 1'b0;
        run_wait(10, 0, starts, dones, cyc);
        @(posedge clk); #2;
        total++;
        if (dones != 1 || o_ts_spike_count !== 14'd17) begin
            bad++;
            $display("FAIL full_run: got dones=%0d cnt=%0d, expected 1 17", dones, o_ts_spike_count);
        end
        i_evt_ready = 1'b1;
        for (int i = 0; i < 40 && o_evt_valid; i++) begin
            @(posedge clk); #2;
        end
        i_evt_ready = 1'b0;
        total++;
        if (pop_cnt != 17 || sb.size() != 0 || o_overflow !== 1'b0) begin
            bad++;
            $display("FAIL full_drain: got pops=%0d left=%0d ovf=%b, expected 17 0 0",
                     pop_cnt, sb.size(), o_overflow);
        end
    endtask

    task automatic test_abort();
        int starts, cyc, act;
        sb.delete(); i_evt_ready = 1'b0;
        set_model(2, 10, 20, 5, 4);
        model_en = 1'b1;
        pulse_run(8'd3);
        starts = 0; cyc = 0;
        while (starts < 2 && cyc < 100) begin
            @(posedge clk); #2;
            i_run_start = 1'b0;
            cyc++;
            if (o_core_start) starts++;
        end
        repeat (4) @(posedge clk);
        #2;
        total++;
        if (starts != 2 || o_evt_valid !== 1'b1 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_setup: got starts=%0d valid=%b busy=%b, expected 2 1 1",
                     starts, o_evt_valid, o_busy);
        end
        i_abort = 1'b1;
        @(posedge clk); #2;
        i_abort = 1'b0;
        total++;
        if (o_busy !== 1'b0 || o_evt_valid !== 1'b0 || o_run_done !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: got busy=%b valid=%b done=%b, expected 0 0 0",
                     o_busy, o_evt_valid, o_run_done);
        end
        total++;
        if (o_cur_ts !== 8'd1 || o_ts_spike_count !== 14'd2 || o_overflow !== 1'b0) begin
            bad++;
            $display("FAIL abort_hold: got cur_ts=%0d cnt=%0d ovf=%b, expected 1 2 0",
                     o_cur_ts, o_ts_spike_count, o_overflow);
        end
        act = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #2;
            if (o_run_done || o_core_start || o_evt_valid || o_busy) act++;
        end
        total++;
        if (act != 0) begin
            bad++;
            $display("FAIL abort_after: got %0d active cycles, expected 0", act);
        end
        sb.delete();
        model_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int starts, cyc;
        sb.delete(); i_evt_ready = 1'b0;
        set_model(2, 0, 20, 5, 4);
        model_en = 1'b1;
        pulse_run(8'd2);
        starts = 0; cyc = 0;
        while (starts < 2 && cyc < 100) begin
            @(posedge clk); #2;
            i_run_start = 1'b0;
            cyc++;
            if (o_core_start) starts++;
        end
        repeat (5) @(posedge clk);
        #2;
        total++;
        if (o_cur_ts !== 8'd1 || o_evt_valid !== 1'b1 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_setup: got cur_ts=%0d valid=%b busy=%b, expected 1 1 1",
                     o_cur_ts, o_evt_valid, o_busy);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({o_core_start, o_evt_valid, o_evt_addr, o_evt_ts, o_cur_ts, o_ts_spike_count,
             o_busy, o_run_done, o_overflow} !== '0) begin
            bad++;
            $display("FAIL rst_async: got busy=%b valid=%b cur_ts=%0d cnt=%0d, expected all 0",
                     o_busy, o_evt_valid, o_cur_ts, o_ts_spike_count);
        end
        @(negedge clk); rst = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        total++;
        if (o_busy !== 1'b0 || o_evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_after: got busy=%b valid=%b, expected 0 0", o_busy, o_evt_valid);
        end
        sb.delete();
        model_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_run();
        test_zero_timesteps();
        test_idle_spike();
        test_ignored_start();
        test_overflow();
        test_full_push_pop();
        test_abort();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/snn_timestep_sched.md
# snn_timestep_sched

Run-level scheduler that sits above the neuron-sweep controller. It sequences a host-requested number of SNN timesteps by pulsing the sweep controller's start and waiting for its done. It captures every output spike event into a timestep-tagged event FIFO for downstream consumers. It also reports per-timestep spike counts and overflow status.

## Interface
- ADDR_WIDTH, 14: neuron address width; matches the sweep controller's spike address.
- TS_WIDTH, 8: timestep counter / tag width.
- CNT_WIDTH, 14: per-timestep spike counter width.
- FIFO_AW, 4: log2 of event FIFO depth (depth 16).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- i_run_start  in  1  one-cycle run request; sampled only in S_IDLE.
- i_num_timesteps  in  TS_WIDTH  timesteps to run; latched with i_run_start.
- i_abort  in  1  synchronous abort, effective in any state.
- o_core_start  out  1  one-cycle start pulse to the sweep controller.
- i_core_done  in  1  one-cycle sweep-complete pulse from the sweep controller.
- i_spike_valid  in  1  output spike event strobe from the sweep controller.
- i_spike_addr  in  ADDR_WIDTH  spiking neuron index.
- o_evt_valid  out  1  FIFO head valid (first-word fall-through).
- o_evt_addr  out  ADDR_WIDTH  head event neuron index.
- o_evt_ts  out  TS_WIDTH  head event timestep tag.
- i_evt_ready  in  1  consumer pop; a pop occurs when o_evt_valid & i_evt_ready.
- o_cur_ts  out  TS_WIDTH  current timestep index.
- o_ts_spike_count  out  CNT_WIDTH  spike count of the last completed timestep.
- o_busy  out  1  high in every state except S_IDLE.
- o_run_done  out  1  one-cycle pulse at run completion.
- o_overflow  out  1  sticky flag: an event was dropped because the FIFO was full.

## Operation
- States: S_IDLE, S_LAUNCH, S_WAIT_CORE, S_TS_END, S_FINISH.
- S_IDLE, on i_run_start:
  - latch i_num_timesteps; clear o_cur_ts, the spike counter and o_overflow.
  - if the latched value is 0, go to S_FINISH; otherwise go to S_LAUNCH.
- S_LAUNCH: o_core_start = 1 for exactly this cycle; next state S_WAIT_CORE.
- S_WAIT_CORE: hold until i_core_done, then go to S_TS_END. There is no timeout.
- S_TS_END:
  - o_ts_spike_count <= counter plus any spike accepted this cycle; the counter is cleared.
  - if o_cur_ts == num-1, go to S_FINISH with o_cur_ts held.
  - otherwise o_cur_ts <= o_cur_ts+1 and go to S_LAUNCH.
- S_FINISH: o_run_done = 1 for this cycle; next state S_IDLE.
- i_abort has priority over all transitions:
  - next state is S_IDLE; the FIFO is flushed (pointers cleared).
  - no o_run_done pulse is issued.
  - o_cur_ts, o_ts_spike_count and o_overflow hold their values.
  - the sweep controller is not stopped; spikes arriving after the abort are ignored.
- Spike capture:
  - spikes are accepted only when o_busy = 1; spikes seen in S_IDLE are ignored.
  - each accepted spike enqueues {o_cur_ts, i_spike_addr} and increments the counter.
  - the counter saturates at 2^CNT_WIDTH-1.
- FIFO:
  - depth 2^FIFO_AW; o_evt_valid = not empty.
  - when full: a push with no simultaneous pop is dropped, o_overflow is set, and the counter still increments.
  - when full with a simultaneous push and pop: both succeed and there is no overflow.
  - when empty with a simultaneous push and pop-ready: there is no bypass; the event appears the next cycle.
- i_run_start while o_busy = 1 is ignored.

## Timing
- Reset values:
  - all outputs are 0 (o_core_start, o_evt_valid, o_evt_addr, o_evt_ts, o_cur_ts, o_ts_spike_count, o_busy, o_run_done, o_overflow).
  - state is S_IDLE; FIFO pointers, counter and latched count are 0.
- Reset taking effect mid-run returns everything to these values immediately (asynchronous).
- Start latency:
  - i_run_start is sampled at edge k; o_busy and o_core_start are high in cycle k+1.
  - o_core_start is decoded from the registered state only, so it is glitch-free and exactly one cycle long.
- Done to restart:
  - i_core_done is sampled at edge m; S_TS_END occupies cycle m+1; the next o_core_start is high in cycle m+2.
- Last timestep:
  - S_FINISH (o_run_done high) occupies cycle m+2; o_busy falls in cycle m+3.
- Zero-timestep run: o_run_done is high in cycle k+1 and o_core_start never asserts.
- Spike to FIFO head:
  - a spike accepted at edge j is visible on o_evt_* from cycle j+1 if the FIFO was empty.
  - head data changes only on a pop.
- o_ts_spike_count updates at the edge ending S_TS_END.
- o_overflow sets at the edge of the dropped push.

## Test plan
- Normal run: i_num_timesteps=3; the core model returns done 20 cycles after each start and emits 2 spikes (addr 5, 9) per sweep; i_evt_ready=1. Expect:
  - exactly 3 o_core_start pulses.
  - events (0,5),(0,9),(1,5),(1,9),(2,5),(2,9) in order.
  - o_ts_spike_count=2 after each timestep; o_cur_ts ends at 2; one o_run_done; o_overflow=0.
- Zero timesteps: i_num_timesteps=0 -> o_run_done in cycle k+1, no o_core_start, o_busy high for exactly 1 cycle.
- Overflow: i_evt_ready=0; 20 spikes in one sweep. Expect:
  - 16 events retained, o_overflow=1, o_ts_spike_count=20.
  - a subsequent pop sequence yields the first 16 addresses in order.
- Full with simultaneous push and pop: fill to 16 entries, then hold a spike and i_evt_ready high together for 1 cycle -> occupancy stays 16 and o_overflow stays 0.
- Abort and reset: i_abort during S_WAIT_CORE of timestep 1 -> S_IDLE next cycle, FIFO empty, no o_run_done, and later spikes ignored. Then rst asserted mid-run -> all outputs 0 immediately.
- Ignored inputs: i_run_start pulsed while busy -> no effect on the timestep sequence. A spike in S_IDLE -> o_evt_valid stays 0.
